data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port, word-addressed data memory between the CPU load/store path (m0) and a debug/loader port (m1).
- Memory has combinational read and a synchronous write on the rising edge of clk.
- Arbiter owns the memory-side address, write-enable and write-data lines.
- Uses a registered ownership FSM with round-robin selection and a burst limit to prevent starvation; read data is returned registered.

Parameters:
- ADDR_W, 16, word-address width driven to memory.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive accesses by one owner while the other requester is waiting; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m0_req  in  1  requester 0 access request; held until the access completes.
- m0_we  in  1  requester 0 write (1) / read (0).
- m0_addr  in  ADDR_W  requester 0 word address.
- m0_wdata  in  DATA_W  requester 0 write data.
- m0_gnt  out  1  access performed this cycle.
- m0_rvalid  out  1  read data valid; one cycle after a granted read.
- m0_rdata  out  DATA_W  registered read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to m0 for requester 1.
- mem_addr  out  ADDR_W  address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rd  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset is asynchronous, active-high on reset; clock is clk.
- Reset state: state=IDLE, rr_last=1 (so m0 wins the first tie), burst_cnt=0. All outputs are 0: gnt, rvalid, rdata, mem_*.
- FSM states are IDLE, OWN0 and OWN1; transitions occur on the rising clk edge.
- IDLE:
  - No grant is issued; mem_we=0; mem_addr/mem_wdata=0.
  - Only m0_req -> OWN0. Only m1_req -> OWN1.
  - Both requesting -> the port != rr_last.
  - Neither -> stay in IDLE.
  - Arbitration latency: one cycle from req to first gnt.
- OWNx:
  - mem_addr, mem_wdata and mem_we are driven combinationally from port x's inputs.
  - mx_gnt = mx_req; mem_we = mx_req & mx_we.
  - Each cycle with mx_gnt=1 counts as exactly one access; a write commits at that clock edge.
  - A read is captured as mx_rdata <= mem_rd, with mx_rvalid=1 for exactly the next cycle. Otherwise rvalid=0 and rdata holds its last value.
  - The non-owner's gnt is 0; its req is simply held (no loss, no error).
  - burst_cnt increments on each granted cycle while the other port is requesting; it clears on any ownership change.
- OWNx exit:
  - mx_req=0 and other requesting -> OWNother, with no IDLE bubble.
  - mx_req=0 and other idle -> IDLE.
  - Other requesting and burst_cnt reaches MAX_BURST-1 with this cycle granted -> OWNother on the next edge (forced handover).
  - On every exit rr_last <= x.
- Simultaneous events:
  - A read granted in the last owner cycle still returns rvalid next cycle, overlapping the new owner's first grant; each port has its own rdata/rvalid.
  - MAX_BURST=1 gives strict alternation under contention.
- Reset mid-operation:
  - State returns to IDLE immediately; mem_we drops asynchronously.
  - A write in the cycle where reset asserts is not committed.
  - A pending rvalid is cleared.
- Addresses beyond memory depth are not checked; the address is passed through unmodified.

Optional Feature:
- Macro: DATA_MEM_ARB_STATS_EN.
- When defined, these output ports are added:
  - m0_grant_cnt [31:0] and m1_grant_cnt [31:0]: count granted cycles per port.
  - conflict_cnt [31:0]: counts cycles where both req are high.
  - All three reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then m0 write addr 0x0010 data 0xDEADBEEF, then m0 read 0x0010 -> m0_gnt one cycle after req; m0_rvalid=1 with m0_rdata=0xDEADBEEF the cycle after the read grant.
- m0 and m1 assert req in the same cycle after reset -> m0 owns first. When m0 drops req, m1_gnt asserts next cycle with no IDLE cycle.
- MAX_BURST=8, m0 holds req continuously with 20 accesses and m1 requests at cycle 0 -> m0 gets exactly 8 grants, then m1 is granted. When m1 drops, m0 resumes.
- Reset asserted mid-write (m1 writing 0x12345678 to 0x0003) -> mem_we=0 immediately; memory[3] is unchanged; all outputs are 0; the first grant after release goes to whichever port requests, with m0 winning a tie.
- Back-to-back reads at 0x0001/0x0002 by m1 (preloaded 0xA, 0xB) -> m1_rvalid high for 2 consecutive cycles with rdata 0xA then 0xB; m0_rvalid stays 0.
- With DATA_MEM_ARB_STATS_EN, run 5 m0 grants, 3 m1 grants and 4 contention cycles -> m0_grant_cnt=5, m1_grant_cnt=3, conflict_cnt=4.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port, word-addressed data memory between
// the CPU load/store path (m0) and a debug/loader port (m1). A registered
// ownership FSM (IDLE/OWN0/OWN1) gives round-robin selection with a burst
// limit, so a busy owner cannot starve the other port. Memory reads are
// combinational; the read word is returned registered one cycle after the grant.
// Optional build macro: DATA_MEM_ARB_STATS_EN adds grant and conflict counters.
module data_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DATA_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       m0_grant_cnt,
  output logic [31:0]       m1_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             rr_last, rr_last_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic             own_req, oth_req;
  logic [1:0]       other_state;

  // Memory-side mux and grants: the current owner's lines pass straight through.
  always_comb begin
    m0_gnt    = (state == OWN0) && m0_req;
    m1_gnt    = (state == OWN1) && m1_req;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      OWN0: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = m0_gnt && m0_we;
      end
      OWN1: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_we    = m1_gnt && m1_we;
      end
      default: ;
    endcase
  end

  // Ownership transitions: round-robin on ties, handover on release or burst limit.
  always_comb begin
    own_req     = (state == OWN1) ? m1_req : m0_req;
    oth_req     = (state == OWN1) ? m0_req : m1_req;
    other_state = (state == OWN1) ? OWN0 : OWN1;
    state_nxt   = state;
    rr_last_nxt = rr_last;
    burst_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        burst_nxt = '0;
        if (m0_req && m1_req) state_nxt = rr_last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // Release, or this granted cycle is the last one allowed while the other waits.
        if (!own_req || (oth_req && (burst_cnt == BURST_LAST))) begin
          state_nxt   = oth_req ? other_state : IDLE;
          rr_last_nxt = (state == OWN1);
          burst_nxt   = '0;
        end else if (oth_req) begin
          burst_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  // FSM state registers; rr_last starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Registered read return per port; rdata holds its last value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rd;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rd;
    end
  end

`ifdef DATA_MEM_ARB_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (m0_gnt)           m0_grant_cnt <= m0_grant_cnt + 32'd1;
      if (m1_gnt)           m1_grant_cnt <= m1_grant_cnt + 32'd1;
      if (m0_req && m1_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized and directed stimulus with a transaction-level
// reference model (owner / contested-grant streak / last owner) and a scoreboard
// of expected read data that an independent monitor drains on rvalid.
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rd;
  logic [AW-1:0] mem_addr;
`ifdef DATA_MEM_ARB_STATS_EN
  logic [31:0]   m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
`ifdef DATA_MEM_ARB_STATS_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side memory: 16 words, low address bits select the word.
  bit [DW-1:0] mem [16];
  assign mem_rd = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

  typedef struct { bit idle; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { logic [DW-1:0] data; int cyc; } rd_t;

  cmd_t cq0[$], cq1[$];
  rd_t  q0[$], q1[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  bit   busy0 = 0, busy1 = 0, seen0 = 0, seen1 = 0;
  int   gseq[$], gcyc[$], iss0[$], rvc0[$], rvc1[$];
  logic [DW-1:0] rvd0[$], rvd1[$];

  // Reference model state
  int   owner = -1, last = 1, streak = 0;
  bit   pend_we = 0;
  logic [3:0] pend_a = '0;
  logic [DW-1:0] pend_d = '0;
  bit [DW-1:0] ref_mem [16];
  int unsigned e_g0 = 0, e_g1 = 0, e_cf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input bit idle, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.idle = idle; c.we = we; c.addr = a; c.data = d;
    return c;
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; streak = 0; pend_we = 0;
    seen0 = 0; seen1 = 0;
    q0.delete(); q1.delete();
    e_g0 = 0; e_g1 = 0; e_cf = 0;
  endtask

  // One cycle of the reference model, evaluated with inputs stable before the edge.
  task automatic model_cycle();
    bit r0, r1, eg0, eg1, rx, ry;
    int x;
    r0 = m0_req; r1 = m1_req;
    eg0 = (owner == 0) && r0;
    eg1 = (owner == 1) && r1;
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("mem_we", mem_we, (eg0 && m0_we) || (eg1 && m1_we));
    if (owner < 0) begin
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_wdata, 0);
    end
    if (eg0) begin
      chk("mem_addr_m0", mem_addr, m0_addr);
      if (m0_we) chk("mem_wdata_m0", mem_wdata, m0_wdata);
    end
    if (eg1) begin
      chk("mem_addr_m1", mem_addr, m1_addr);
      if (m1_we) chk("mem_wdata_m1", mem_wdata, m1_wdata);
    end
`ifdef DATA_MEM_ARB_STATS_EN
    chk("m0_grant_cnt", m0_grant_cnt, e_g0);
    chk("m1_grant_cnt", m1_grant_cnt, e_g1);
    chk("conflict_cnt", conflict_cnt, e_cf);
`endif
    e_g0 += eg0; e_g1 += eg1; e_cf += (r0 && r1);
    if (eg0 || eg1) begin gseq.push_back(eg0 ? 0 : 1); gcyc.push_back(cyc); end
    if (eg0) begin
      if (m0_we) begin pend_we = 1; pend_a = m0_addr[3:0]; pend_d = m0_wdata; end
      else q0.push_back('{ref_mem[m0_addr[3:0]], cyc});
    end
    if (eg1) begin
      if (m1_we) begin pend_we = 1; pend_a = m1_addr[3:0]; pend_d = m1_wdata; end
      else q1.push_back('{ref_mem[m1_addr[3:0]], cyc});
    end
    // Ownership for the next cycle
    if (owner < 0) begin
      if (r0 && r1) owner = 1 - last;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
    end else begin
      x  = owner;
      rx = (x == 0) ? r0 : r1;
      ry = (x == 0) ? r1 : r0;
      if (rx && ry) streak++;
      if (!rx) begin
        owner = ry ? 1 - x : -1; last = x; streak = 0;
      end else if (ry && streak >= MB) begin
        owner = 1 - x; last = x; streak = 0;
      end
    end
    seen0 = m0_gnt; seen1 = m1_gnt;
  endtask

  // Model process: reset, write commit at the edge, arbitration before the edge.
  initial forever begin
    @(posedge clk or negedge clk or posedge reset);
    if (reset) model_reset();
    else if (clk) begin
      cyc++;
      if (pend_we) ref_mem[pend_a] = pend_d;
      pend_we = 0;
    end else model_cycle();
  end

  // Monitor: pops expected read data whenever a port presents rvalid.
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m0_rvalid) begin
          rvc0.push_back(cyc); rvd0.push_back(m0_rdata);
          if (q0.size() == 0) chk("m0_rvalid_spurious", 1, 0);
          else begin
            e = q0.pop_front();
            chk("m0_rdata", m0_rdata, e.data);
            chk("m0_rvalid_lat", cyc, e.cyc + 1);
          end
        end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
          e = q0.pop_front();
          chk("m0_rvalid_missing", 0, 1);
        end
        if (m1_rvalid) begin
          rvc1.push_back(cyc); rvd1.push_back(m1_rdata);
          if (q1.size() == 0) chk("m1_rvalid_spurious", 1, 0);
          else begin
            e = q1.pop_front();
            chk("m1_rdata", m1_rdata, e.data);
            chk("m1_rvalid_lat", cyc, e.cyc + 1);
          end
        end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
          e = q1.pop_front();
          chk("m1_rvalid_missing", 0, 1);
        end
      end
    end
  end

  // Driver: each port holds req until it has seen its grant, then takes the next command.
  task automatic drive();
    cmd_t c;
    if (busy0 && seen0) busy0 = 0;
    if (!busy0 && cq0.size() > 0) begin
      c = cq0.pop_front();
      if (!c.idle) begin
        busy0 = 1; m0_we = c.we; m0_addr = c.addr; m0_wdata = c.data;
        iss0.push_back(cyc);
      end
    end
    m0_req = busy0;
    if (busy1 && seen1) busy1 = 0;
    if (!busy1 && cq1.size() > 0) begin
      c = cq1.pop_front();
      if (!c.idle) begin
        busy1 = 1; m1_we = c.we; m1_addr = c.addr; m1_wdata = c.data;
      end
    end
    m1_req = busy1;
  endtask

  task automatic step();
    @(posedge clk); #1; drive();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((busy0 || busy1 || cq0.size() > 0 || cq1.size() > 0) && n < maxc) begin
      step(); n++;
    end
    chk("drain_within_budget", n < maxc, 1);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    gseq.delete(); gcyc.delete(); iss0.delete();
    rvc0.delete(); rvc1.delete(); rvd0.delete(); rvd1.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m0_gnt"}, m0_gnt, 0);
    chk({tag, "_m1_gnt"}, m1_gnt, 0);
    chk({tag, "_m0_rvalid"}, m0_rvalid, 0);
    chk({tag, "_m1_rvalid"}, m1_rvalid, 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
`ifdef DATA_MEM_ARB_STATS_EN
    chk({tag, "_m0_grant_cnt"}, m0_grant_cnt, 0);
    chk({tag, "_m1_grant_cnt"}, m1_grant_cnt, 0);
    chk({tag, "_conflict_cnt"}, conflict_cnt, 0);
`endif
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1 reset = 1;
    busy0 = 0; busy1 = 0; cq0.delete(); cq1.delete();
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    #1 reset = 0;
  endtask

  initial begin
    int bad;
    int found;
    int exp_seq[$];
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, found;
    int exp_seq[$];
    logic [DW-1:0] a_d;
    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk); #1 reset = 0;

    // m0 write then read back, one-cycle arbitration latency
    clear_logs();
    cq0.push_back(mk(0, 1, 16'h0010, 32'hDEADBEEF));
    cq0.push_back(mk(0, 0, 16'h0010, 32'h0));
    drain(50);
    chk("t1_grants", gseq.size(), 2);
    if (gcyc.size() >= 2 && iss0.size() >= 1) begin
      chk("t1_first_gnt_latency", gcyc[0], iss0[0] + 1);
      chk("t1_rvalid_cycle", (rvc0.size() == 1) ? rvc0[0] : -1, gcyc[1] + 1);
    end
    chk("t1_rdata", (rvd0.size() == 1) ? rvd0[0] : 32'h0, 32'hDEADBEEF);

    // Reset in the middle of an m1 write
    cq1.push_back(mk(0, 1, 16'h0003, 32'h12345678));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      @(negedge clk);
      if (m1_gnt) found = 1;
    end
    chk("rst_write_granted", found, 1);
    #1 reset = 1;
    #1 chk("rst_mem_we_async", mem_we, 0);
    chk_zero("midreset");
    busy0 = 0; busy1 = 0; cq0.delete(); cq1.delete();
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1 chk("rst_mem3_unchanged", mem[3], 0);
    @(negedge clk); #1 reset = 0;

    // Simultaneous requests after reset: m0 first, m1 right after m0 drops req
    clear_logs();
    repeat (2) begin
      cq0.push_back(mk(0, 0, 16'h0005, 0));
      cq1.push_back(mk(0, 1, 16'h0006, 32'h00C0FFEE));
    end
    drain(50);
    chk("tie_order", (gseq.size() == 4) ? {gseq[0][3:0], gseq[1][3:0], gseq[2][3:0], gseq[3][3:0]} : 16'hFFFF, 16'h0011);
    if (gcyc.size() == 4) chk("tie_handover_gap", gcyc[2] - gcyc[1], 2);

    // Burst limit: m0 has 20 accesses, m1 requests from the start
    clear_logs();
    for (int i = 0; i < 20; i++) cq0.push_back(mk(0, i[0], AW'(i), DW'(i * 3)));
    for (int i = 0; i < 3; i++)  cq1.push_back(mk(0, 0, AW'(i + 8), 0));
    drain(100);
    exp_seq.delete();
    for (int i = 0; i < 8; i++)  exp_seq.push_back(0);
    for (int i = 0; i < 3; i++)  exp_seq.push_back(1);
    for (int i = 0; i < 12; i++) exp_seq.push_back(0);
    chk("burst_len", gseq.size(), exp_seq.size());
    bad = 0;
    for (int i = 0; i < gseq.size() && i < exp_seq.size(); i++) if (gseq[i] != exp_seq[i]) bad++;
    chk("burst_seq_mismatches", bad, 0);
    if (gcyc.size() > 8) chk("burst_forced_handover", gcyc[8] - gcyc[7], 1);

    // Back-to-back m1 reads of preloaded words
    cq1.push_back(mk(0, 1, 16'h0001, 32'hA));
    cq1.push_back(mk(0, 1, 16'h0002, 32'hB));
    drain(50);
    clear_logs();
    cq1.push_back(mk(0, 0, 16'h0001, 0));
    cq1.push_back(mk(0, 0, 16'h0002, 0));
    drain(50);
    chk("b2b_rvalid_count", rvc1.size(), 2);
    if (rvc1.size() == 2) begin
      chk("b2b_consecutive", rvc1[1] - rvc1[0], 1);
      chk("b2b_first", rvd1[0], 32'hA);
      chk("b2b_second", rvd1[1], 32'hB);
    end
    chk("b2b_m0_rvalid_quiet", rvc0.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cq0.push_back(mk($urandom_range(3) == 0, $urandom_range(1), AW'($urandom), $urandom));
      cq1.push_back(mk($urandom_range(3) == 0, $urandom_range(1), AW'($urandom), $urandom));
    end
    drain(5000);

`ifdef DATA_MEM_ARB_STATS_EN
    // Statistics: 5 m0 grants, 3 m1 grants, 4 contention cycles
    reset_pulse();
    for (int i = 0; i < 5; i++) cq0.push_back(mk(0, 0, AW'(i), 0));
    cq1.push_back(mk(1, 0, 0, 0));
    cq1.push_back(mk(1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cq1.push_back(mk(0, 1, AW'(i + 4), DW'(i)));
    drain(50);
    @(negedge clk);
    chk("stats_m0", m0_grant_cnt, 5);
    chk("stats_m1", m1_grant_cnt, 3);
    chk("stats_conflict", conflict_cnt, 4);
`endif

    @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
